// File: rtl/ysyx_24090012_lsu_if.sv
// Bundle of the LSU's EXU-side, memory-side and writeback-side handshake signals.
// The master modport is the LSU's view of the bundle. The slave modport is the view of its surroundings.
interface ysyx_24090012_lsu_if;
    logic        exu_valid;
    logic        exu_ready;
    logic [31:0] exu_addr;
    logic [31:0] exu_wdata;
    logic [31:0] exu_rd_data;
    logic [31:0] exu_inst;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;

    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_err;

    logic        wb_valid;
    logic        wb_ready;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] wb_inst;

    logic        lsu_err;
    logic [1:0]  state_out;

    modport master (
        input  exu_valid, exu_addr, exu_wdata, exu_rd_data, exu_inst,
        output exu_ready,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_rdata, mem_resp_err,
        output wb_valid, wb_wen, wb_rd, wb_data, wb_inst,
        input  wb_ready,
        output lsu_err, state_out
    );

    modport slave (
        output exu_valid, exu_addr, exu_wdata, exu_rd_data, exu_inst,
        input  exu_ready,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_rdata, mem_resp_err,
        input  wb_valid, wb_wen, wb_rd, wb_data, wb_inst,
        output wb_ready,
        input  lsu_err, state_out
    );
endinterface

// File: rtl/ysyx_24090012_lsu.sv
// Single-outstanding load/store unit: IDLE -> REQ -> WAIT -> DONE, non-memory instructions bypass to DONE.
// Optional macro YSYX_LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault without a bus request.
module ysyx_24090012_lsu (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_24090012_lsu_if.master       bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rd_data;
    logic [31:0] r_inst;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_in_ls;
    logic        w_trap;

    assign w_accept = bus.exu_valid && (r_state == S_IDLE);
    assign w_in_ls  = (bus.exu_inst[6:0] == OPC_LOAD) || (bus.exu_inst[6:0] == OPC_STORE);

`ifdef YSYX_LSU_MISALIGN_TRAP_EN
    // funct3[1:0]: 00 byte, 01 half, 1x word (loads 011/110/111 behave as LW).
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a != 2'b00));
    endfunction
    assign w_trap = w_in_ls && misaligned(bus.exu_inst[14:12], bus.exu_addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        w_next            = r_state;
        bus.exu_ready     = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.wb_valid      = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.exu_ready = 1'b1;
                if (bus.exu_valid) w_next = (w_in_ls && !w_trap) ? S_REQ : S_DONE;
            end
            S_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_resp_valid) w_next = S_DONE;
            end
            S_DONE: begin
                bus.wb_valid = 1'b1;
                if (bus.wb_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Load data is cleared on acceptance so a trapped or bypassed instruction never shows stale bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
            r_inst    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_addr    <= bus.exu_addr;
            r_wdata   <= bus.exu_wdata;
            r_rd_data <= bus.exu_rd_data;
            r_inst    <= bus.exu_inst;
            r_rdata   <= '0;
            r_err     <= w_trap;
        end else if ((r_state == S_WAIT) && bus.mem_resp_valid) begin
            r_rdata   <= bus.mem_resp_rdata;
            r_err     <= bus.mem_resp_err;
        end
    end

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_writes_rd;
    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;
    logic [31:0] w_load_data;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;

    assign w_opcode   = r_inst[6:0];
    assign w_f3       = r_inst[14:12];
    assign w_is_load  = (w_opcode == OPC_LOAD);
    assign w_is_store = (w_opcode == OPC_STORE);

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = r_wdata;
        if (w_is_store) begin
            case (w_f3[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << r_addr[1:0];
                    w_wdata = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    w_wstrb = 4'b0011 << {r_addr[1], 1'b0};
                    w_wdata = {2{r_wdata[15:0]}};
                end
                default: w_wstrb = 4'b1111;
            endcase
        end
    end

    // Halves select by addr[1] only and words always use lane 0, so misaligned low bits are ignored.
    assign w_byte_sh = r_rdata >> {r_addr[1:0], 3'b000};
    assign w_half_sh = r_rdata >> {r_addr[1], 4'b0000};

    always_comb begin
        case (w_f3)
            3'b000:  w_load_data = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            3'b100:  w_load_data = {24'h000000, w_byte_sh[7:0]};
            3'b001:  w_load_data = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            3'b101:  w_load_data = {16'h0000, w_half_sh[15:0]};
            default: w_load_data = r_rdata;
        endcase
    end

    assign w_writes_rd = w_is_load || (w_opcode == OPC_OP) || (w_opcode == OPC_OP_IMM)
                      || (w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC)
                      || (w_opcode == OPC_JAL) || (w_opcode == OPC_JALR)
                      || ((w_opcode == OPC_SYSTEM) && (w_f3 != 3'b000));

    assign bus.mem_req_wen   = w_is_store;
    assign bus.mem_req_addr  = {r_addr[31:2], 2'b00};
    assign bus.mem_req_wstrb = w_wstrb;
    assign bus.mem_req_wdata = w_wdata;

    assign bus.wb_wen    = w_writes_rd && (r_inst[11:7] != 5'd0) && !r_err;
    assign bus.wb_rd     = r_inst[11:7];
    assign bus.wb_data   = w_is_load ? w_load_data : r_rd_data;
    assign bus.wb_inst   = r_inst;
    assign bus.lsu_err   = r_err;
    assign bus.state_out = r_state;
endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// Bench for ysyx_24090012_lsu: directed vector table, reset corner cases, and random transactions vs a reference model.
module tb_ysyx_24090012_lsu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_24090012_lsu_if bus ();
    ysyx_24090012_lsu dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPR = 7'b0110011, OPI = 7'b0010011;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] SYS = 7'b1110011, BRANCH = 7'b1100011;
    logic [6:0] ops [10] = '{LOAD, STORE, OPR, OPI, LUI, AUIPC, JAL, JALR, SYS, BRANCH};

    typedef struct {
        logic req; logic [31:0] addr; logic wen; logic [3:0] wstrb; logic [31:0] wdata;
        logic wb_wen; logic [4:0] rd; logic chk_data; logic [31:0] data; logic err;
    } exp_t;

    typedef struct {
        logic [31:0] inst, addr, wdata, rd_data, rdata; logic err; int req_lat, wb_lat; exp_t e;
    } vec_t;

    typedef struct {
        int first_lat; logic req_seen; logic [31:0] req_addr; logic req_wen; logic [3:0] req_wstrb;
        logic [31:0] req_wdata; logic req_stable, wait_ok, wb_seen, wb_wen; logic [4:0] wb_rd;
        logic [31:0] wb_data, wb_inst; logic err, wb_stable, idle_after;
    } obs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {12'h123, 5'd4, f3, rd, op};
    endfunction

    function automatic exp_t ex(input logic req, input logic [31:0] addr, input logic wen, input logic [3:0] wstrb,
                                input logic [31:0] wdata, input logic wb_wen, input logic [4:0] rd,
                                input logic chk, input logic [31:0] data, input logic err);
        exp_t e;
        e.req = req; e.addr = addr; e.wen = wen; e.wstrb = wstrb; e.wdata = wdata;
        e.wb_wen = wb_wen; e.rd = rd; e.chk_data = chk; e.data = data; e.err = err;
        return e;
    endfunction

    function automatic vec_t vec(input logic [31:0] inst, addr, wdata, rd_data, rdata, input logic err,
                                 input int req_lat, wb_lat, input exp_t e);
        vec_t v;
        v.inst = inst; v.addr = addr; v.wdata = wdata; v.rd_data = rd_data; v.rdata = rdata;
        v.err = err; v.req_lat = req_lat; v.wb_lat = wb_lat; v.e = e;
        return v;
    endfunction

    // Reference: access size in bytes, lane = offset rounded down to the size, data moved by byte arithmetic.
    function automatic exp_t model(input logic [31:0] inst, addr, wdata, rd_data, rdata, input logic err);
        exp_t e;
        logic [6:0] op; logic [2:0] f3; int size, lane; logic [31:0] raw, mask; logic is_ld, is_st, writes;
        op = inst[6:0]; f3 = inst[14:12];
        is_ld = (op == LOAD); is_st = (op == STORE);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        lane = (int'(addr[1:0]) / size) * size;
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        raw = (rdata >> (8 * lane)) & mask;
        if (is_ld && !f3[2] && size < 4 && raw[8 * size - 1]) raw = raw | ~mask;
        writes = is_ld || (op inside {OPR, OPI, LUI, AUIPC, JAL, JALR}) || (op == SYS && f3 != 3'b000);
        e.req = is_ld || is_st;
        e.addr = addr & 32'hFFFF_FFFC;
        e.wen = is_st;
        e.wstrb = 4'(((1 << size) - 1) << lane);
        e.wdata = (size == 1) ? 32'(wdata[7:0]) * 32'h0101_0101 :
                  (size == 2) ? 32'(wdata[15:0]) * 32'h0001_0001 : wdata;
        e.err = e.req && err;
        e.wb_wen = writes && (inst[11:7] != 5'd0) && !e.err;
        e.rd = inst[11:7];
        e.chk_data = !is_st && !(is_ld && err);
        e.data = is_ld ? raw : rd_data;
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
        if (e.req && (int'(addr[1:0]) % size) != 0) begin
            e.req = 1'b0; e.err = 1'b1; e.wb_wen = 1'b0; e.chk_data = 1'b0;
        end
`endif
        return e;
    endfunction

    task automatic idle_inputs();
        bus.exu_valid = 1'b0; bus.exu_addr = '0; bus.exu_wdata = '0; bus.exu_rd_data = '0; bus.exu_inst = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0; bus.mem_resp_err = 1'b0;
        bus.wb_ready = 1'b0;
    endtask

    // Drives one instruction end to end, with every wait bounded, and records what the LSU showed.
    task automatic do_txn(input logic [31:0] inst, addr, wdata, rd_data, rdata, input logic err,
                          input int req_lat, wb_lat, output obs_t o);
        int n;
        o = '{default: 0};
        o.req_stable = 1'b1; o.wait_ok = 1'b1; o.wb_stable = 1'b1;
        @(negedge clk);
        bus.exu_valid = 1'b1; bus.exu_inst = inst; bus.exu_addr = addr;
        bus.exu_wdata = wdata; bus.exu_rd_data = rd_data;
        @(negedge clk);
        bus.exu_valid = 1'b0; bus.exu_inst = $urandom; bus.exu_addr = $urandom;
        bus.exu_wdata = $urandom; bus.exu_rd_data = $urandom;
        n = 0;
        while (!bus.mem_req_valid && !bus.wb_valid && n < 20) begin @(negedge clk); n++; end
        o.first_lat = n;
        if (bus.mem_req_valid) begin
            o.req_seen = 1'b1; o.req_addr = bus.mem_req_addr; o.req_wen = bus.mem_req_wen;
            o.req_wstrb = bus.mem_req_wstrb; o.req_wdata = bus.mem_req_wdata;
            if (bus.state_out !== 2'b01 || bus.wb_valid || bus.exu_ready) o.req_stable = 1'b0;
            for (int i = 0; i < req_lat; i++) begin
                bus.mem_resp_valid = 1'($urandom_range(0, 1));
                bus.mem_resp_rdata = $urandom; bus.mem_resp_err = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (bus.mem_req_valid !== 1'b1 || bus.state_out !== 2'b01 || bus.mem_req_addr !== o.req_addr ||
                    bus.mem_req_wen !== o.req_wen || bus.mem_req_wstrb !== o.req_wstrb ||
                    bus.mem_req_wdata !== o.req_wdata) o.req_stable = 1'b0;
            end
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                if (bus.state_out !== 2'b10 || bus.mem_req_valid || bus.wb_valid) o.wait_ok = 1'b0;
                @(negedge clk);
            end
            if (bus.state_out !== 2'b10 || bus.mem_req_valid || bus.wb_valid) o.wait_ok = 1'b0;
            bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = rdata; bus.mem_resp_err = err;
            @(negedge clk);
            bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = $urandom; bus.mem_resp_err = 1'b0;
        end
        n = 0;
        while (!bus.wb_valid && n < 20) begin @(negedge clk); n++; end
        if (bus.wb_valid) begin
            o.wb_seen = 1'b1; o.wb_wen = bus.wb_wen; o.wb_rd = bus.wb_rd; o.wb_data = bus.wb_data;
            o.wb_inst = bus.wb_inst; o.err = bus.lsu_err;
            for (int i = 0; i < wb_lat; i++) begin
                bus.mem_resp_valid = 1'($urandom_range(0, 1));
                bus.mem_resp_rdata = $urandom; bus.mem_resp_err = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (bus.wb_valid !== 1'b1 || bus.state_out !== 2'b11 || bus.exu_ready || bus.mem_req_valid ||
                    bus.wb_wen !== o.wb_wen || bus.wb_rd !== o.wb_rd || bus.wb_data !== o.wb_data ||
                    bus.wb_inst !== o.wb_inst || bus.lsu_err !== o.err) o.wb_stable = 1'b0;
            end
            bus.mem_resp_valid = 1'b0;
            bus.wb_ready = 1'b1;
            @(negedge clk);
            bus.wb_ready = 1'b0;
            o.idle_after = (bus.state_out === 2'b00) && bus.exu_ready && !bus.wb_valid;
        end
    endtask

    task automatic compare(input string tag, input logic [31:0] inst, input exp_t e, input obs_t o);
        check({tag, "_first_lat"}, 32'(o.first_lat), 32'd0);
        check({tag, "_req_seen"}, 32'(o.req_seen), 32'(e.req));
        if (e.req && o.req_seen) begin
            check({tag, "_req_addr"}, o.req_addr, e.addr);
            check({tag, "_req_wen"}, 32'(o.req_wen), 32'(e.wen));
            check({tag, "_req_stable"}, 32'(o.req_stable), 32'd1);
            check({tag, "_wait_ok"}, 32'(o.wait_ok), 32'd1);
            if (e.wen) begin
                check({tag, "_wstrb"}, 32'(o.req_wstrb), 32'(e.wstrb));
                check({tag, "_wdata"}, o.req_wdata, e.wdata);
            end
        end
        check({tag, "_wb_seen"}, 32'(o.wb_seen), 32'd1);
        if (o.wb_seen) begin
            check({tag, "_wb_wen"}, 32'(o.wb_wen), 32'(e.wb_wen));
            check({tag, "_wb_rd"}, 32'(o.wb_rd), 32'(e.rd));
            check({tag, "_wb_inst"}, o.wb_inst, inst);
            check({tag, "_lsu_err"}, 32'(o.err), 32'(e.err));
            if (e.chk_data) check({tag, "_wb_data"}, o.wb_data, e.data);
            check({tag, "_wb_stable"}, 32'(o.wb_stable), 32'd1);
            check({tag, "_idle_after"}, 32'(o.idle_after), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl [15];
        obs_t  o;
        exp_t  e;
        logic [31:0] r, inst, addr, wd, rdd, rdt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        er;

        tbl[0]  = vec(mk(LOAD, 3'b000, 5'd5), 32'h8000_0003, 32'h0, 32'h0, 32'h80FF_1234, 1'b0, 0, 0,
                      ex(1, 32'h8000_0000, 0, 4'h0, 32'h0, 1, 5'd5, 1, 32'hFFFF_FF80, 0));
        tbl[1]  = vec(mk(STORE, 3'b001, 5'd7), 32'h8000_0102, 32'h0000_ABCD, 32'h0, 32'h0, 1'b0, 1, 0,
                      ex(1, 32'h8000_0100, 1, 4'b1100, 32'hABCD_ABCD, 0, 5'd7, 0, 32'h0, 0));
        tbl[2]  = vec(mk(OPI, 3'b000, 5'd3), 32'h0, 32'h0, 32'h11, 32'h0, 1'b0, 0, 3,
                      ex(0, 32'h0, 0, 4'h0, 32'h0, 1, 5'd3, 1, 32'h11, 0));
        tbl[3]  = vec(mk(LOAD, 3'b010, 5'd9), 32'h0000_1000, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 4, 1,
                      ex(1, 32'h0000_1000, 0, 4'h0, 32'h0, 0, 5'd9, 0, 32'h0, 1));
        tbl[4]  = vec(mk(STORE, 3'b010, 5'd0), 32'h0000_0010, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 0, 0,
                      ex(1, 32'h0000_0010, 1, 4'b1111, 32'h1234_5678, 0, 5'd0, 0, 32'h0, 0));
        tbl[5]  = vec(mk(LOAD, 3'b100, 5'd1), 32'h0000_0022, 32'h0, 32'h0, 32'h11A5_3344, 1'b0, 2, 0,
                      ex(1, 32'h0000_0020, 0, 4'h0, 32'h0, 1, 5'd1, 1, 32'h0000_00A5, 0));
        tbl[6]  = vec(mk(LOAD, 3'b001, 5'd2), 32'h0000_0046, 32'h0, 32'h0, 32'h8001_7FFF, 1'b0, 0, 2,
                      ex(1, 32'h0000_0044, 0, 4'h0, 32'h0, 1, 5'd2, 1, 32'hFFFF_8001, 0));
        tbl[7]  = vec(mk(LOAD, 3'b101, 5'd4), 32'h0000_0044, 32'h0, 32'h0, 32'h8001_F00D, 1'b0, 1, 0,
                      ex(1, 32'h0000_0044, 0, 4'h0, 32'h0, 1, 5'd4, 1, 32'h0000_F00D, 0));
        tbl[8]  = vec(mk(STORE, 3'b000, 5'd11), 32'h0000_0101, 32'hFFFF_FF5A, 32'h0, 32'h0, 1'b0, 0, 0,
                      ex(1, 32'h0000_0100, 1, 4'b0010, 32'h5A5A_5A5A, 0, 5'd11, 0, 32'h0, 0));
        tbl[9]  = vec(mk(LUI, 3'b101, 5'd0), 32'h0, 32'h0, 32'hABCD_E000, 32'h0, 1'b0, 0, 0,
                      ex(0, 32'h0, 0, 4'h0, 32'h0, 0, 5'd0, 1, 32'hABCD_E000, 0));
        tbl[10] = vec(mk(SYS, 3'b000, 5'd6), 32'h0, 32'h0, 32'h55, 32'h0, 1'b0, 0, 0,
                      ex(0, 32'h0, 0, 4'h0, 32'h0, 0, 5'd6, 1, 32'h55, 0));
        tbl[11] = vec(mk(SYS, 3'b010, 5'd6), 32'h0, 32'h0, 32'h77, 32'h0, 1'b0, 0, 0,
                      ex(0, 32'h0, 0, 4'h0, 32'h0, 1, 5'd6, 1, 32'h77, 0));
        tbl[12] = vec(mk(LOAD, 3'b110, 5'd8), 32'h0000_0008, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 0,
                      ex(1, 32'h0000_0008, 0, 4'h0, 32'h0, 1, 5'd8, 1, 32'hCAFE_F00D, 0));
        tbl[13] = vec(mk(BRANCH, 3'b001, 5'd10), 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 0,
                      ex(0, 32'h0, 0, 4'h0, 32'h0, 0, 5'd10, 1, 32'h0, 0));
        tbl[14] = vec(mk(LOAD, 3'b000, 5'd0), 32'h0000_0030, 32'h0, 32'h0, 32'h0000_007F, 1'b0, 0, 0,
                      ex(1, 32'h0000_0030, 0, 4'h0, 32'h0, 0, 5'd0, 1, 32'h0000_007F, 0));

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(bus.state_out), 32'd0);
        check("rst_exu_ready", 32'(bus.exu_ready), 32'd1);
        check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_wb_wen", 32'(bus.wb_wen), 32'd0);
        check("rst_lsu_err", 32'(bus.lsu_err), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_wb_inst", bus.wb_inst, 32'd0);
        check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_state", 32'(bus.state_out), 32'd0);
        check("post_rst_exu_ready", 32'(bus.exu_ready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            do_txn(tbl[i].inst, tbl[i].addr, tbl[i].wdata, tbl[i].rd_data, tbl[i].rdata, tbl[i].err,
                   tbl[i].req_lat, tbl[i].wb_lat, o);
            compare($sformatf("vec%0d", i), tbl[i].inst, tbl[i].e, o);
        end

        // Misaligned word load: faults locally when trapping, otherwise reads lane 0 of the aligned word.
        inst = mk(LOAD, 3'b010, 5'd1);
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
        e = ex(0, 32'h0, 0, 4'h0, 32'h0, 0, 5'd1, 0, 32'h0, 1);
`else
        e = ex(1, 32'h0, 0, 4'h0, 32'h0, 1, 5'd1, 1, 32'h1357_9BDF, 0);
`endif
        do_txn(inst, 32'h0000_0002, 32'h0, 32'h0, 32'h1357_9BDF, 1'b0, 0, 0, o);
        compare("lw_misaligned", inst, e, o);

        // Reset while waiting for a response; the late response must be dropped.
        @(negedge clk);
        bus.exu_valid = 1'b1; bus.exu_inst = mk(LOAD, 3'b010, 5'd9); bus.exu_addr = 32'h200;
        @(negedge clk);
        bus.exu_valid = 1'b0;
        check("wait_rst_in_req", 32'(bus.state_out), 32'd1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("wait_rst_in_wait", 32'(bus.state_out), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("wait_rst_state", 32'(bus.state_out), 32'd0);
        check("wait_rst_wb_inst", bus.wb_inst, 32'd0);
        bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'hFFFF_FFFF; bus.mem_resp_err = 1'b1;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0; bus.mem_resp_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("late_resp_state%0d", i), 32'(bus.state_out), 32'd0);
            check($sformatf("late_resp_wb_valid%0d", i), 32'(bus.wb_valid), 32'd0);
            check($sformatf("late_resp_err%0d", i), 32'(bus.lsu_err), 32'd0);
            @(negedge clk);
        end

        // Reset while a store request is still waiting for mem_req_ready.
        bus.exu_valid = 1'b1; bus.exu_inst = mk(STORE, 3'b010, 5'd0); bus.exu_addr = 32'h300;
        @(negedge clk);
        bus.exu_valid = 1'b0;
        check("req_rst_in_req", 32'(bus.mem_req_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("req_rst_state", 32'(bus.state_out), 32'd0);
        check("req_rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("req_rst_req_wen", 32'(bus.mem_req_wen), 32'd0);

        for (int k = 0; k < 200; k++) begin
            op = ops[$urandom_range(0, 9)];
            f3 = (op == STORE) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r = $urandom;
            inst = {r[31:15], f3, rd, op};
            addr = $urandom; wd = $urandom; rdd = $urandom; rdt = $urandom;
            er = ($urandom_range(0, 3) == 0);
            e = model(inst, addr, wd, rdd, rdt, er);
            do_txn(inst, addr, wd, rdd, rdt, er, $urandom_range(0, 3), $urandom_range(0, 2), o);
            compare($sformatf("rnd%0d", k), inst, e, o);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ysyx_24090012_lsu.md
YSYX_24090012_LSU -- requirements
Module: ysyx_24090012_lsu

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset (synchronous, active-high).
REQ-002 SHALL have: exu_valid  in  1  EXU request valid; exu_ready  out  1  LSU accepts request.
REQ-003 SHALL have: exu_addr  in  32  effective address; exu_wdata  in  32  store data (rs2); exu_rd_data  in  32  ALU result; exu_inst  in  32  instruction.
REQ-004 SHALL have: mem_req_valid  out  1; mem_req_ready  in  1; mem_req_wen  out  1; mem_req_addr  out  32; mem_req_wdata  out  32; mem_req_wstrb  out  4.
REQ-005 SHALL have: mem_resp_valid  in  1; mem_resp_rdata  in  32; mem_resp_err  in  1.
REQ-006 SHALL have: wb_valid  out  1; wb_ready  in  1; wb_wen  out  1; wb_rd  out  5; wb_data  out  32; wb_inst  out  32.
REQ-007 SHALL have: lsu_err  out  1  access fault for the instruction on wb_*; state_out  out  2  current state.

Function
REQ-008 SHALL implement states IDLE=00, REQ=01, WAIT=10, DONE=11; state_out reflects the current state.
REQ-009 exu_ready SHALL be 1 only in IDLE; on exu_valid&&exu_ready, addr, wdata, rd_data, inst SHALL be latched.
REQ-010 Load (opcode 0000011) or store (0100011) SHALL go IDLE->REQ; any other opcode SHALL go IDLE->DONE with no bus access (1-cycle bypass, wb_data=latched rd_data).
REQ-011 REQ: mem_req_valid=1 with stable fields until mem_req_ready; handshake -> WAIT.
REQ-012 WAIT: mem_resp_valid -> DONE, capture rdata and err; mem_resp_valid in IDLE/REQ/DONE SHALL be ignored.
REQ-013 DONE: wb_valid=1 with stable outputs until wb_ready; handshake -> IDLE (no same-cycle acceptance of next request).
REQ-014 mem_req_wen=1 for stores; mem_req_addr = latched address with bits[1:0] cleared.
REQ-015 Stores: SB wstrb=0001<<addr[1:0], wdata={4{byte}}; SH wstrb=0011<<{addr[1],0}, wdata={2{half}}; SW wstrb=1111, full word.
REQ-016 Loads: shift rdata right by 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; funct3 011/110/111 treated as LW.
REQ-017 wb_wen=1 for loads, OP, OP-IMM, LUI, AUIPC, JAL, JALR and SYSTEM with funct3!=0, only if rd!=0 and no error; wb_rd=inst[11:7]; wb_inst=latched inst.
REQ-018 mem_resp_err=1 SHALL set lsu_err=1 and force wb_wen=0; stores set wb_wen=0 always.

Reset
REQ-019 rst SHALL force IDLE from any state, including REQ/WAIT mid-transaction; an outstanding response is dropped.
REQ-020 During/after reset: exu_ready=1 (IDLE), mem_req_valid=0, wb_valid=0, wb_wen=0, lsu_err=0, all latched registers and wb_data/wb_inst/wb_rd=0, state_out=00.

Configuration
REQ-021 Macro YSYX_LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL go IDLE->DONE with no bus request, lsu_err=1, wb_wen=0.
REQ-022 Macro undefined: misaligned accesses SHALL proceed with low address bits ignored per REQ-015/016 (half uses addr[1], word uses lane 0); lsu_err only from mem_resp_err.

Verification
REQ-023 LB addr=0x80000003, rdata=0x80FF_1234, rd=5 -> req addr 0x80000000, wen=0; wb_data=0xFFFFFF80, wb_wen=1, wb_rd=5.
REQ-024 SH addr=0x80000102, wdata=0x0000ABCD -> wstrb=1100, mem_req_wdata=0xABCDABCD, wb_wen=0.
REQ-025 ADDI rd=3, rd_data=0x11 -> no mem_req_valid; wb_valid 1 cycle after acceptance, wb_data=0x11; wb_ready held low 3 cycles -> outputs stable, exu_ready=0.
REQ-026 LW with mem_req_ready low 4 cycles then mem_resp_err=1 -> req fields stable 4 cycles; lsu_err=1, wb_wen=0.
REQ-027 rst asserted in WAIT, late mem_resp_valid after reset -> state 00, wb_valid stays 0.
REQ-028 LW addr=0x2 with YSYX_LSU_MISALIGN_TRAP_EN -> no mem_req_valid, lsu_err=1; without macro -> req addr 0x0, wb_data=rdata.
